clockdiv_multi: RTL
===================

# clockdiv_multi

Parametrised multi-channel clock divider that generates, from one system clock, up to CHANNELS independent tick and square-wave strobes, each with its own runtime-programmable period. It succeeds the fixed two-output 50 MHz divider. It adds per-channel divisors loaded through a write port, glitch-free divisor changes at period boundaries, a global enable, and a synchronous phase-restart that aligns all channels. It sits between the board clock and the PWM/sampling blocks, which consume the `tick` pulses as clock enables.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16)
- `CNT_W`, 32: width of divisors and counters
- `DEFAULT_DIV`, 10: divisor loaded into every channel at reset (50 MHz → 5 MHz)
- `CH_W`, derived: `$clog2(CHANNELS)`, minimum 1
- `clk_in`  in  1  system clock (50 MHz)
- `rst`  in  1  reset; synchronous to `clk_in`, active-high
- `en`  in  1  global count enable
- `sync_restart`  in  1  one-cycle pulse; restarts all channels in phase
- `wr_en`  in  1  divisor write request, one cycle
- `wr_chan`  in  CH_W  target channel index
- `wr_div`  in  CNT_W  new divisor (period in `clk_in` cycles)
- `wr_ack`  out  1  one-cycle pulse, the cycle after every `wr_en`
- `wr_err`  out  1  with `wr_ack`: set when `wr_chan >= CHANNELS` (write dropped)
- `tick`  out  CHANNELS  per-channel one-cycle strobe, once per period
- `sq`  out  CHANNELS  per-channel square wave, same period

## Operation
- Per-channel state:
  - `period` (active divisor)
  - `pend`/`pend_v` (pending divisor and its valid flag)
  - `cnt` (0..period-1)
- Reset (edge with `rst`=1):
  - `period`=DEFAULT_DIV, `pend_v`=0, `cnt`=0
  - `tick`=0, `sq`=0, `wr_ack`=0, `wr_err`=0
  - Reset wins over every other input on the same edge.
- Count, at each edge with `en`=1 and `period`>0:
  - If `cnt`==`period`-1: `cnt`<=0 and `tick`<=1 (wrap). Otherwise `cnt`<=`cnt`+1 and `tick`<=0.
  - `sq`<=1 when next `cnt` < `period`/2 (floor), else 0.
  - `period`=10 gives 5 high / 5 low. `period`=3 gives 1 high / 2 low.
- `period`=1: `tick` is constantly 1 while enabled; `sq` stays 0.
- `period`=0: channel disabled. `cnt` is held at 0; `tick`=0 and `sq`=0.
- `en`=0: `cnt` and `sq` hold their values; `tick`=0.
- Write:
  - A valid `wr_en` stores `wr_div` into `pend` of `wr_chan` and sets `pend_v`.
  - A second write before the pending value is applied overwrites it (last writer wins).
- Apply: `pend` moves to `period` and `pend_v` is cleared on the first of:
  - a wrap edge
  - a `sync_restart` edge
  - any edge while `period`=0

  On a wrap edge, the new period governs the next period, starting with `cnt`=0.
- Same-edge collision: write vs. apply. The apply uses the pending value held before the edge. The value written on that edge becomes the new pending.
- `sync_restart`, in every channel:
  - `cnt`<=0, `tick`<=0, `sq`<=(`period`>0)
  - a valid pending divisor is applied
  - takes effect regardless of `en`
- Invalid channel: with `wr_chan` >= CHANNELS, the write is dropped and state is untouched. `wr_ack` and `wr_err` are both 1 the next cycle.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- After `rst` deasserts, with `en`=1: `cnt` sees 0 at the first edge, and `tick` first goes high after edge `period`, then every `period` cycles.
- `wr_ack` rises 1 cycle after `wr_en`, independent of `en`.
- A divisor change never shortens or truncates a period in progress; the new period starts exactly at the wrap.
- After `sync_restart`, all enabled channels with equal `period` tick on the same cycle, `period` edges later.
- Asserting `rst` mid-period: outputs are 0 the cycle after the reset edge, and pending writes are discarded.

## Structure
- Shared package `clockdiv_pkg`:
  - `div_t` (`logic [CNT_W-1:0]`)
  - channel-state struct {`period`, `pend`, `pend_v`, `cnt`}
  - `DEFAULT_DIV` constant
- Sub-module `divchan`: one channel, with the count, apply and `sq` logic. It is instantiated CHANNELS times in a generate loop.
- The top level holds the write decoder, `wr_ack`/`wr_err`, and the fan-out of `en`/`sync_restart`.

## Test plan
- Reset, `en`=1, defaults → `tick[*]` high every 10 cycles, first high 10 edges after reset release; `sq` shows 5 high / 5 low.
- Write ch1=4 at `cnt`=3 of a 10-period → current period finishes at 10; then ticks every 4 cycles; `wr_ack`=1, `wr_err`=0 one cycle after `wr_en`.
- Write ch0=0, then ch0=3 → ch0 silent (`tick`=0, `sq`=0); resumes with period 3 one edge after the second write; `sq` 1 high / 2 low.
- Channels set to 6 with random phases; pulse `sync_restart` → all `tick`s coincide 6 cycles later and stay aligned.
- `wr_chan`=CHANNELS (e.g. 4 with CHANNELS=4) → `wr_ack`=1, `wr_err`=1; no channel period changes.
- Write and wrap on the same edge; toggle `en` low for 3 cycles; assert `rst` mid-period → apply uses the old pending value; `cnt` frozen and `tick`=0 while disabled; all outputs 0 after reset.

Source files
------------

// File: rtl/clockdiv_pkg.sv
// clockdiv_pkg: shared types, defaults and helpers for the multi-channel clock divider
package clockdiv_pkg;

    localparam int PKG_CNT_W   = 32;
    localparam int DEFAULT_DIV = 10;

    typedef logic [PKG_CNT_W-1:0] div_t;

    typedef struct packed {
        div_t period;
        div_t pend;
        logic pend_v;
        div_t cnt;
    } chan_t;

    // square wave is high for the first floor(period/2) counts of each period
    function automatic logic sq_level(div_t cnt, div_t per);
        return cnt < (per >> 1);
    endfunction

endpackage

// File: rtl/clockdiv_multi_divchan.sv
// divchan: one divider channel with glitch-free divisor apply, tick and square outputs
module divchan
    import clockdiv_pkg::*;
#(
    parameter int INIT_DIV = DEFAULT_DIV
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    input  logic sync_restart,
    input  logic wr,
    input  div_t wr_div,
    output logic tick,
    output logic sq
);

    chan_t s;
    logic  wrap;
    logic  apply;
    div_t  nper;
    div_t  ncnt;

    // next-state terms: wrap point, apply condition, effective next period and count
    always_comb begin
        wrap  = (s.period != '0) && (s.cnt == s.period - 1'b1);
        apply = s.pend_v && (sync_restart || (s.period == '0) || (en && wrap));
        nper  = apply ? s.pend : s.period;
        ncnt  = wrap ? '0 : s.cnt + 1'b1;
    end

    // channel state; a write on the apply edge becomes the next pending value
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s    <= '{period: div_t'(INIT_DIV), pend: '0, pend_v: 1'b0, cnt: '0};
            tick <= 1'b0;
            sq   <= 1'b0;
        end else begin
            s.period <= nper;
            s.pend_v <= wr | (s.pend_v & ~apply);
            if (wr)
                s.pend <= wr_div;
            if (sync_restart) begin
                s.cnt <= '0;
                tick  <= 1'b0;
                sq    <= (nper != '0);
            end else if (s.period == '0) begin
                s.cnt <= '0;
                tick  <= 1'b0;
                sq    <= 1'b0;
            end else if (en) begin
                s.cnt <= ncnt;
                tick  <= wrap;
                sq    <= sq_level(ncnt, nper);
            end else begin
                tick  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clockdiv_multi.sv
// clockdiv_multi: multi-channel programmable clock divider with write port and phase restart
module clockdiv_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = clockdiv_pkg::DEFAULT_DIV,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                en,
    input  logic                sync_restart,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_chan,
    input  logic [CNT_W-1:0]    wr_div,
    output logic                wr_ack,
    output logic                wr_err,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq
);

    import clockdiv_pkg::*;

    logic wr_ok;
    div_t div_w;

    // channel index range check and divisor normalised to the channel counter width
    always_comb begin
        wr_ok = 32'(wr_chan) < CHANNELS;
        div_w = div_t'(wr_div);
    end

    // every write is acknowledged next cycle; out-of-range writes are flagged and dropped
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_en;
            wr_err <= wr_en & ~wr_ok;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        divchan #(.INIT_DIV(DEFAULT_DIV)) u_ch (
            .clk_in       (clk_in),
            .rst          (rst),
            .en           (en),
            .sync_restart (sync_restart),
            .wr           (wr_en && wr_ok && (32'(wr_chan) == i)),
            .wr_div       (div_w),
            .tick         (tick[i]),
            .sq           (sq[i])
        );
    end

endmodule
